// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RISC-V load-store unit.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction
// and the misaligned/illegal-size fault flag.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wd_rep,
  output logic [31:0] rd_ext,
  output logic        fault
);

  logic [31:0] rd_shift;
  logic [3:0]  be_raw;

  assign rd_shift = rd_word >> {addr_lo, 3'b000};

  always_comb begin
    be_raw = 4'b0000;
    wd_rep = 32'd0;
    rd_ext = 32'd0;
    fault  = 1'b0;
    case (size)
      LDST_B, LDST_BU: begin
        be_raw = 4'b0001 << addr_lo;
        wd_rep = {4{wd[7:0]}};
        rd_ext = (size == LDST_B) ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                  : {24'd0, rd_shift[7:0]};
      end
      LDST_H, LDST_HU: begin
        be_raw = 4'b0011 << {addr_lo[1], 1'b0};
        wd_rep = {2{wd[15:0]}};
        rd_ext = (size == LDST_H) ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                  : {16'd0, rd_shift[15:0]};
        fault  = addr_lo[0];
      end
      LDST_W: begin
        be_raw = 4'b1111;
        wd_rep = wd;
        rd_ext = rd_word;
        fault  = (addr_lo != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

  // Loads never drive byte enables; the bus returns the whole word.
  assign be = we ? be_raw : 4'b0000;

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: IDLE/BUSY/DONE sequencer with bus timeout between the
// single-cycle core data port and a ready-handshaked word memory.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  lsu_state_t    state;
  logic          we_q;
  logic [2:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wd_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rd_q;
  logic          err_q;

  logic          in_idle, in_busy;
  logic          a_we;
  logic [2:0]    a_size;
  logic [1:0]    a_addr_lo;
  logic [31:0]   a_wd;
  logic [3:0]    be;
  logic [31:0]   wd_rep, rd_ext;
  logic          fault;

  assign in_idle = (state == IDLE);
  assign in_busy = (state == BUSY);

  // In IDLE the fault check must see the incoming request; afterwards the
  // latched fields drive the bus.
  assign a_we      = in_idle ? core_we_i        : we_q;
  assign a_size    = in_idle ? core_size_i      : size_q;
  assign a_addr_lo = in_idle ? core_addr_i[1:0] : addr_q[1:0];
  assign a_wd      = in_idle ? core_wd_i        : wd_q;

  riscv_lsu_align u_align (
    .we      (a_we),
    .size    (a_size),
    .addr_lo (a_addr_lo),
    .wd      (a_wd),
    .rd_word (mem_rd_i),
    .be      (be),
    .wd_rep  (wd_rep),
    .rd_ext  (rd_ext),
    .fault   (fault)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      size_q <= 3'd0;
      addr_q <= 32'd0;
      wd_q   <= 32'd0;
      cnt    <= '0;
      rd_q   <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req_i) begin
            we_q   <= core_we_i;
            size_q <= core_size_i;
            addr_q <= core_addr_i;
            wd_q   <= core_wd_i;
            cnt    <= '0;
            if (fault) begin
              state <= DONE;
              err_q <= 1'b1;
              rd_q  <= 32'd0;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            state <= DONE;
            err_q <= 1'b0;
            rd_q  <= we_q ? 32'd0 : rd_ext;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= DONE;
              err_q <= 1'b1;
              rd_q  <= 32'd0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign core_stall_o = (in_idle && core_req_i) || in_busy;
  assign core_rd_o    = (state == DONE) ? rd_q : 32'd0;
  assign err_o        = (state == DONE) && err_q;

  assign mem_req_o  = in_busy;
  assign mem_we_o   = in_busy && we_q;
  assign mem_be_o   = in_busy ? be : 4'b0000;
  assign mem_addr_o = in_busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wd_o   = (in_busy && we_q) ? wd_rep : 32'd0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed vector table, randomized
// accesses against a byte-level reference model, and reset/late-ready sequences.
module tb_riscv_lsu;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = 32'd0;
  logic [31:0] core_wd_i = 32'd0;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i = 32'd0;
  logic        mem_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  riscv_lsu #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdw;
    int          lat;    // BUSY cycle on which ready is given; 0 = never
    logic [31:0] e_rd;
    logic        e_err;
    int          e_stall;
    int          e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
  } vec_t;

  // Issues one access (starting just after a clock edge) and observes it at
  // each falling edge until the stall drops.
  task automatic run_access(input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdw, input int lat,
                            output int n_stall, output int n_req,
                            output logic [31:0] rd, output logic err,
                            output logic [3:0] be, output logic [31:0] mwd,
                            output logic mwe, output logic [31:0] maddr,
                            output logic done);
    n_stall = 0; n_req = 0; rd = 0; err = 0; be = 0; mwd = 0; mwe = 0;
    maddr = 0; done = 0;
    core_req_i = 1'b1; core_we_i = we; core_size_i = size;
    core_addr_i = addr; core_wd_i = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_i);
      if (core_stall_o) n_stall++;
      if (mem_req_o) begin
        n_req++;
        if (n_req == 1) begin
          be = mem_be_o; mwd = mem_wd_o; mwe = mem_we_o; maddr = mem_addr_o;
        end
        mem_ready_i = (n_req == lat);
        mem_rd_i = (n_req == lat) ? rdw : $urandom;
      end else begin
        mem_ready_i = 1'b0;
      end
      if (!core_stall_o) begin
        rd = core_rd_o; err = err_o; done = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    core_req_i = 1'b0;
    mem_ready_i = 1'b0;
    // Guaranteed idle gap before the next instruction.
    @(posedge clk_i); #1;
  endtask

  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Reference model: derives expectations from byte counts and offsets.
  function automatic vec_t model(input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdw, input int lat);
    vec_t v;
    int n, off;
    logic [31:0] val, mask;
    logic [7:0] b;
    bit to;
    n = nbytes(size);
    off = int'(addr % 4);
    v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.rdw = rdw; v.lat = lat;
    v.e_rd = 0; v.e_err = 0; v.e_be = 0; v.e_wd = 0;
    if (n == 0 || (addr % n) != 0) begin
      v.e_err = 1; v.e_stall = 1; v.e_req = 0;
      return v;
    end
    to = (lat == 0) || (lat > TO);
    v.e_req   = to ? TO : lat;
    v.e_stall = v.e_req + 1;
    if (we) begin
      v.e_be = 4'(((1 << n) - 1) << off);
      for (int i = 0; i < 4; i++) begin
        b = 8'(wd >> (8 * (i % n)));
        v.e_wd = v.e_wd | (32'(b) << (8 * i));
      end
    end
    if (to) begin
      v.e_err = 1;
    end else if (!we) begin
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
      val = (rdw >> (8 * off)) & mask;
      if (size < 3'd4 && n < 4 && val[8*n-1]) val = val | ~mask;
      v.e_rd = val;
    end
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int n_stall, n_req;
    logic [31:0] rd, mwd, maddr;
    logic err, mwe, done;
    logic [3:0] be;
    run_access(v.we, v.size, v.addr, v.wd, v.rdw, v.lat,
               n_stall, n_req, rd, err, be, mwd, mwe, maddr, done);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stall_cycles"}, n_stall, v.e_stall);
    chk({tag, " req_cycles"}, n_req, v.e_req);
    chk({tag, " err"}, 32'(err), 32'(v.e_err));
    if (!v.we) chk({tag, " rd"}, rd, v.e_rd);
    if (v.e_req > 0) begin
      chk({tag, " addr"}, maddr, v.addr & 32'hFFFF_FFFC);
      chk({tag, " be"}, 32'(be), 32'(v.e_be));
      chk({tag, " we"}, 32'(mwe), 32'(v.we));
      if (v.we) chk({tag, " wd"}, mwd, v.e_wd);
    end
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 3'd0, 32'h103, 32'h0, 32'h80AB_CDEF, 1, 32'hFFFF_FF80, 1'b0, 2, 1, 4'b0000, 32'h0};
    tbl[1] = '{1'b1, 3'd1, 32'h202, 32'h1234_5678, 32'h0, 1, 32'h0, 1'b0, 2, 1, 4'b1100, 32'h5678_5678};
    tbl[2] = '{1'b0, 3'd5, 32'h010, 32'h0, 32'h0000_9ABC, 3, 32'h0000_9ABC, 1'b0, 4, 3, 4'b0000, 32'h0};
    tbl[3] = '{1'b0, 3'd2, 32'h006, 32'h0, 32'h0, 1, 32'h0, 1'b1, 1, 0, 4'b0000, 32'h0};
    tbl[4] = '{1'b0, 3'd2, 32'h040, 32'h0, 32'h0, 0, 32'h0, 1'b1, 5, 4, 4'b0000, 32'h0};
    tbl[5] = '{1'b1, 3'd0, 32'h101, 32'h0000_00A5, 32'h0, 2, 32'h0, 1'b0, 3, 2, 4'b0010, 32'hA5A5_A5A5};
    tbl[6] = '{1'b0, 3'd1, 32'h022, 32'h0, 32'h8001_1234, 1, 32'hFFFF_8001, 1'b0, 2, 1, 4'b0000, 32'h0};
    tbl[7] = '{1'b0, 3'd3, 32'h000, 32'h0, 32'h0, 1, 32'h0, 1'b1, 1, 0, 4'b0000, 32'h0};
    tbl[8] = '{1'b1, 3'd2, 32'h300, 32'hDEAD_BEEF, 32'h0, 1, 32'h0, 1'b0, 2, 1, 4'b1111, 32'hDEAD_BEEF};
    tbl[9] = '{1'b0, 3'd4, 32'h001, 32'h0, 32'h0000_F000, 4, 32'h0000_00F0, 1'b0, 5, 4, 4'b0000, 32'h0};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset stall", 32'(core_stall_o), 32'd0);
    chk("reset req", 32'(mem_req_o), 32'd0);
    chk("reset err", 32'(err_o), 32'd0);
    chk("reset rd", core_rd_o, 32'd0);
    chk("reset bus", {mem_addr_o[27:0], mem_be_o}, 32'd0);
    @(posedge clk_i); #1;

    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Ready outside BUSY is ignored
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("late_ready stall", 32'(core_stall_o), 32'd0);
    chk("late_ready req", 32'(mem_req_o), 32'd0);
    chk("late_ready err", 32'(err_o), 32'd0);
    @(posedge clk_i); #1 mem_ready_i = 1'b0;

    // Reset in BUSY cycle 2
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
    core_addr_i = 32'h100; core_wd_i = 32'h0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rstbusy c1 req", 32'(mem_req_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1; core_req_i = 1'b0;
    @(negedge clk_i);
    chk("rstbusy c2 req", 32'(mem_req_o), 32'd1);
    @(posedge clk_i); #1 rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("rstbusy req", 32'(mem_req_o), 32'd0);
      chk("rstbusy stall", 32'(core_stall_o), 32'd0);
      chk("rstbusy err", 32'(err_o), 32'd0);
      chk("rstbusy rd", core_rd_o, 32'd0);
      chk("rstbusy bus", {mem_addr_o[27:0], mem_be_o}, 32'd0);
      @(posedge clk_i); #1;
    end

    // Randomized accesses against the reference model
    for (int i = 0; i < 80; i++) begin
      logic we;
      logic [2:0] size;
      logic [31:0] addr, wd, rdw;
      int lat;
      we = 1'($urandom);
      size = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      wd = $urandom;
      rdw = $urandom;
      lat = $urandom_range(1, TO + 2);
      apply(model(we, size, addr, wd, rdw, lat), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
